// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hazard_state_t;

  localparam int PERF_CNT_W = 32;

  // Saturating increment so long-running counters stick at all-ones.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
    return (value == '1) ? value : value + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use hazard detection between the ID-stage sources and a load in EX.
module load_use_detector (
  input  logic       id_ex_mem_re,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == id_ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == id_ex_rd);
  // x0 is never a real dependency even when a load targets it.
  assign load_use = id_ex_mem_re & (id_ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stage-enable, flush and redirect sequencing for the five-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/load-use counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_ex_mem_re,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_redirect,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       ex_mem_we,
  output logic       mem_wb_we,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pc_sel_target,
  output logic       mem_timeout,
  output logic       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_load_use
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT < 1) ? '0 : CNT_W'(MEM_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

  hazard_state_t    state;
  hazard_state_t    state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             redirect_pending;
  logic             pending_next;

  logic load_use;
  logic mem_stall;
  logic timeout_hit;
  logic release_now;
  logic run_eval;
  logic redir;

  load_use_detector u_load_use_detector (
    .id_ex_mem_re (id_ex_mem_re),
    .id_ex_rd     (id_ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .load_use     (load_use)
  );

  assign mem_stall   = dmem_req & ~dmem_ready;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);
  assign release_now = (state == HZ_MEM_WAIT) & (dmem_ready | timeout_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= HZ_RUN;
      wait_cnt         <= '0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_next;
      wait_cnt         <= wait_cnt_next;
      redirect_pending <= pending_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pending_next  = redirect_pending;
    run_eval      = 1'b0;
    redir         = 1'b0;
    mem_timeout   = 1'b0;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    id_ex_we      = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_we     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_target = 1'b0;
    state_o       = state;

    case (state)
      HZ_RUN: begin
        if (mem_stall) begin
          pending_next  = ex_redirect;
          wait_cnt_next = '0;
          state_next    = HZ_MEM_WAIT;
        end else begin
          run_eval = 1'b1;
          redir    = ex_redirect;
        end
      end
      HZ_MEM_WAIT: begin
        if (release_now) begin
          run_eval     = 1'b1;
          redir        = redirect_pending;
          pending_next = 1'b0;
          state_next   = HZ_RUN;
          mem_timeout  = timeout_hit & ~dmem_ready;
        end else if (wait_cnt != '1) begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      default: state_next = HZ_RUN;
    endcase

    // A redirect squashes the ID instruction, so it outranks the load-use bubble.
    if (run_eval) begin
      if (redir) begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        pc_sel_target = 1'b1;
      end else if (load_use) begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00111;
        id_ex_flush = 1'b1;
      end else begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
      end
    end

    if (!rst_n) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      pc_sel_target = 1'b0;
      mem_timeout   = 1'b0;
      state_o       = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic bubble;
  logic hold_cycle;

  assign bubble     = run_eval & ~redir & load_use;
  assign hold_cycle = (state == HZ_MEM_WAIT) & ~release_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_load_use     <= '0;
    end else begin
      if (bubble | hold_cycle) perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (pc_sel_target)       perf_flushes      <= sat_inc(perf_flushes);
      if (bubble)              perf_load_use     <= sat_inc(perf_load_use);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Table-driven directed bench for pipeline_hazard_controller (MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;

  // Output pattern order: pc,if_id,id_ex,ex_mem,mem_wb we | if_id,id_ex flush | pc_sel | mem_timeout | state_o
  localparam logic [9:0] P_NORMAL = 10'b11111_00_0_0_0;
  localparam logic [9:0] P_BUBBLE = 10'b00111_01_0_0_0;
  localparam logic [9:0] P_REDIR  = 10'b11111_11_1_0_0;
  localparam logic [9:0] P_FREEZE = 10'b00000_00_0_0_0;
  localparam logic [9:0] P_HOLD   = 10'b00000_00_0_0_1;
  localparam logic [9:0] P_RESET  = 10'b00000_11_0_0_0;
  localparam logic [9:0] P_TOREL  = 10'b11111_00_0_1_0;
  localparam logic [9:0] M_ALL    = 10'b11111_11_1_1_1;
  localparam logic [9:0] M_NOST   = 10'b11111_11_1_1_0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       mem_re;
    logic [4:0] rd;
    logic       redirect;
    logic       req;
    logic       ready;
    logic [9:0] exp;
    logic [9:0] mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_ex_mem_re, ex_redirect, dmem_req, dmem_ready;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, pc_sel_target, mem_timeout, state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

  int tests = 0;
  int fails = 0;
  int model_stall = 0;
  int model_flush = 0;
  int model_lu = 0;
  vec_t table_v [10];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_mem_re  (id_ex_mem_re),
    .id_ex_rd      (id_ex_rd),
    .ex_redirect   (ex_redirect),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_we         (pc_we),
    .if_id_we      (if_id_we),
    .id_ex_we      (id_ex_we),
    .ex_mem_we     (ex_mem_we),
    .mem_wb_we     (mem_wb_we),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .pc_sel_target (pc_sel_target),
    .mem_timeout   (mem_timeout),
    .state_o       (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_load_use     (perf_load_use)
`endif
  );

  function automatic vec_t mk(input string name, input logic rst_n_i,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use1, input logic use2, input logic mem_re,
                              input logic [4:0] rd, input logic redirect,
                              input logic req, input logic ready,
                              input logic [9:0] exp, input logic [9:0] mask);
    vec_t v;
    v.name = name; v.rst_n = rst_n_i; v.rs1 = rs1; v.rs2 = rs2;
    v.use1 = use1; v.use2 = use2; v.mem_re = mem_re; v.rd = rd;
    v.redirect = redirect; v.req = req; v.ready = ready;
    v.exp = exp; v.mask = mask;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n        = v.rst_n;
    id_rs1       = v.rs1;
    id_rs2       = v.rs2;
    id_uses_rs1  = v.use1;
    id_uses_rs2  = v.use2;
    id_ex_mem_re = v.mem_re;
    id_ex_rd     = v.rd;
    ex_redirect  = v.redirect;
    dmem_req     = v.req;
    dmem_ready   = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] exp, input logic [9:0] mask);
    logic [9:0] act;
    act = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, pc_sel_target, mem_timeout, state_o};
    tests++;
    if ((act & mask) !== (exp & mask)) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b (mask %b)", name, act, exp, mask);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, check mid-cycle, update the counter model at the edge.
  task automatic step(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v.name, v.exp, v.mask);
    if (!v.rst_n) begin
      model_stall = 0; model_flush = 0; model_lu = 0;
    end else begin
      if (v.exp[2]) model_flush++;
      if (v.exp == P_BUBBLE) begin model_lu++; model_stall++; end
      if (v.exp == P_HOLD) model_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkPerf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    checkValue({tag, "_stall"}, perf_stall_cycles, model_stall);
    checkValue({tag, "_flush"}, perf_flushes, model_flush);
    checkValue({tag, "_lu"}, perf_load_use, model_lu);
`else
    if (tag.len() == 0) $display("[TB] empty perf tag");
`endif
  endtask

  initial begin
    table_v[0] = mk("idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL);
    table_v[1] = mk("lu_rs1",     1, 5, 7, 1, 1, 1, 5, 0, 0, 0, P_BUBBLE, M_ALL);
    table_v[2] = mk("after_lu",   1, 5, 7, 1, 1, 0, 0, 0, 0, 0, P_NORMAL, M_ALL);
    table_v[3] = mk("lu_rd0",     1, 0, 7, 1, 1, 1, 0, 0, 0, 0, P_NORMAL, M_ALL);
    table_v[4] = mk("lu_rs2",     1, 3, 9, 1, 1, 1, 9, 0, 0, 0, P_BUBBLE, M_ALL);
    table_v[5] = mk("rs2_unused", 1, 3, 9, 1, 0, 1, 9, 0, 0, 0, P_NORMAL, M_ALL);
    table_v[6] = mk("not_load",   1, 5, 0, 1, 0, 0, 5, 0, 0, 0, P_NORMAL, M_ALL);
    table_v[7] = mk("redir_lu",   1, 5, 7, 1, 1, 1, 5, 1, 0, 0, P_REDIR,  M_ALL);
    table_v[8] = mk("redir_only", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, P_REDIR,  M_ALL);
    table_v[9] = mk("req_ready",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, P_NORMAL, M_ALL);

    applyStimulus(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, M_ALL));
    @(posedge clk);
    #1;
    step(mk("reset_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_RESET, M_ALL));
    step(mk("reset_b", 0, 5, 5, 1, 1, 1, 5, 1, 1, 0, P_RESET, M_ALL));

    for (int i = 0; i < 10; i++) step(table_v[i]);

    // Memory wait: inputs during hold cycles must be ignored.
    step(mk("mw_enter",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_FREEZE, M_ALL));
    step(mk("mw_hold1",   1, 5, 0, 1, 0, 1, 5, 1, 1, 0, P_HOLD,   M_ALL));
    step(mk("mw_hold2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("mw_release", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, P_NORMAL, M_NOST));
    step(mk("mw_after",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL));

    // Redirect arriving with a freeze is deferred to the release cycle.
    step(mk("dr_enter",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_FREEZE, M_ALL));
    step(mk("dr_hold1",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("dr_hold2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("dr_release", 1, 5, 7, 1, 1, 1, 5, 0, 1, 1, P_REDIR,  M_NOST));
    step(mk("dr_after",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL));

    // Forced release on the fourth MEM_WAIT cycle.
    step(mk("to_enter",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_FREEZE, M_ALL));
    step(mk("to_hold1",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("to_hold2",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("to_hold3",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("to_release", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_TOREL,  M_NOST));
    step(mk("to_after",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL));

    checkPerf("perf_mid");

    // Reset inside a wait drops the pending redirect and never pulses mem_timeout.
    step(mk("rw_enter",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, P_FREEZE, M_ALL));
    step(mk("rw_hold1",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("rw_reset",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_RESET,  M_ALL));
    step(mk("rw_run",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL));
    checkPerf("perf_reset");
    step(mk("rw2_enter",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_FREEZE, M_ALL));
    step(mk("rw2_hold",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_HOLD,   M_ALL));
    step(mk("rw2_release",1, 0, 0, 0, 0, 0, 0, 0, 1, 1, P_NORMAL, M_NOST));
    step(mk("rw2_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NORMAL, M_ALL));
    checkPerf("perf_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
